instr_regfile_pipe: RTL and testbench

INSTR_REGFILE_PIPE -- requirements
Module: instr_regfile_pipe

---
 rtl/instr_regfile_pipe.sv | 176 +++++++++++++++++
 tb/tb_instr_regfile_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_regfile_pipe.sv
// -----------------------------------------------------------------------------
// instr_regfile_pipe
//
// Two-stage instruction register file. An accepted load is captured into a
// stage-1 register on edge E0. On edge E0+1 the result is computed from stage-1
// and written, together with the opcode, both operands, an error flag and a
// valid bit, into entry write_pointer. Entry read_pointer is presented
// combinationally on the read ports.
//
// Optional feature macro: IR_DIV_EN
//   defined   -> DIV/MOD use a signed divider; a zero divisor stores 0, err=1
//   undefined -> no divider is built; DIV/MOD always store 0 with err=1
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   clear          in   synchronous clear of all valid bits, drops stage-1
//   load_valid     in   load request
//   load_ready     out  load can be accepted (= !clear)
//   opcode         in   ZERO,PASSA,PASSB,ADD,SUB,MULT,DIV,MOD (0..7)
//   operand_a/b    in   signed operands, DATA_W bits
//   write_pointer  in   destination entry of the load
//   read_pointer   in   entry shown on the rd_* ports
//   rd_opcode, rd_operand_a, rd_operand_b, rd_result  out  stored fields
//   rd_valid, rd_err out entry status bits
//   rd_pending     out  stage-1 holds a load targeting read_pointer
//   load_count     out  16-bit wrapping count of accepted loads
// -----------------------------------------------------------------------------
module instr_regfile_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [2:0]            opcode,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [ADDR_W-1:0]     write_pointer,
    input  logic [ADDR_W-1:0]     read_pointer,
    output logic [2:0]            rd_opcode,
    output logic [DATA_W-1:0]     rd_operand_a,
    output logic [DATA_W-1:0]     rd_operand_b,
    output logic [2*DATA_W-1:0]   rd_result,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  rd_pending,
    output logic [15:0]           load_count
);

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    // Stage-1 registers
    logic                s1_valid_q, s1_valid_d;
    logic [2:0]          s1_op_q;
    logic [DATA_W-1:0]   s1_a_q;
    logic [DATA_W-1:0]   s1_b_q;
    logic [ADDR_W-1:0]   s1_ptr_q;

    // Entry storage
    logic [2:0]          ent_op_q    [DEPTH];
    logic [DATA_W-1:0]   ent_a_q     [DEPTH];
    logic [DATA_W-1:0]   ent_b_q     [DEPTH];
    logic [2*DATA_W-1:0] ent_res_q   [DEPTH];
    logic                ent_valid_q [DEPTH];
    logic                ent_err_q   [DEPTH];

    logic [15:0]         cnt_q, cnt_d;
    logic                accept;

    logic [2*DATA_W-1:0] res_d;
    logic                err_d;

    assign load_ready = ~clear;
    assign accept     = load_valid & load_ready;
    assign s1_valid_d = accept;
    assign cnt_d      = cnt_q + 16'd1;

    // Result datapath. Operands are sign-extended to 2*DATA_W first so every
    // operation, including MIN/-1 division, fits without overflow.
    always_comb begin
        logic signed [2*DATA_W-1:0] a_ext;
        logic signed [2*DATA_W-1:0] b_ext;
        a_ext = {{DATA_W{s1_a_q[DATA_W-1]}}, s1_a_q};
        b_ext = {{DATA_W{s1_b_q[DATA_W-1]}}, s1_b_q};
        res_d = '0;
        err_d = 1'b0;
        case (s1_op_q)
            OP_ZERO:  res_d = '0;
            OP_PASSA: res_d = a_ext;
            OP_PASSB: res_d = b_ext;
            OP_ADD:   res_d = a_ext + b_ext;
            OP_SUB:   res_d = a_ext - b_ext;
            OP_MULT:  res_d = a_ext * b_ext;
`ifdef IR_DIV_EN
            OP_DIV: begin
                if (s1_b_q == '0) err_d = 1'b1;
                else              res_d = a_ext / b_ext;
            end
            OP_MOD: begin
                if (s1_b_q == '0) err_d = 1'b1;
                else              res_d = a_ext % b_ext;
            end
`else
            OP_DIV:   err_d = 1'b1;
            OP_MOD:   err_d = 1'b1;
`endif
            default:  res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_op_q  <= opcode;
                s1_a_q   <= operand_a;
                s1_b_q   <= operand_b;
                s1_ptr_q <= write_pointer;
                cnt_q    <= cnt_d;
            end
        end
    end

    // Clear drops every valid bit and also suppresses the stage-1 write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_op_q[i]    <= '0;
                ent_a_q[i]     <= '0;
                ent_b_q[i]     <= '0;
                ent_res_q[i]   <= '0;
                ent_valid_q[i] <= 1'b0;
                ent_err_q[i]   <= 1'b0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid_q[i] <= 1'b0;
            end
        end else if (s1_valid_q) begin
            ent_op_q[s1_ptr_q]    <= s1_op_q;
            ent_a_q[s1_ptr_q]     <= s1_a_q;
            ent_b_q[s1_ptr_q]     <= s1_b_q;
            ent_res_q[s1_ptr_q]   <= res_d;
            ent_err_q[s1_ptr_q]   <= err_d;
            ent_valid_q[s1_ptr_q] <= 1'b1;
        end
    end

    assign rd_opcode    = ent_op_q[read_pointer];
    assign rd_operand_a = ent_a_q[read_pointer];
    assign rd_operand_b = ent_b_q[read_pointer];
    assign rd_result    = ent_res_q[read_pointer];
    assign rd_valid     = ent_valid_q[read_pointer];
    assign rd_err       = ent_err_q[read_pointer];
    assign rd_pending   = s1_valid_q && (s1_ptr_q == read_pointer);
    assign load_count   = cnt_q;

endmodule

// File: tb/tb_instr_regfile_pipe.sv
module tb_instr_regfile_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        load_valid;
    logic        load_ready;
    logic [2:0]  opcode;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  write_pointer, read_pointer;
    logic [2:0]  rd_opcode;
    logic [31:0] rd_operand_a, rd_operand_b;
    logic [63:0] rd_result;
    logic        rd_valid, rd_err, rd_pending;
    logic [15:0] load_count;

    instr_regfile_pipe dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .load_valid(load_valid), .load_ready(load_ready),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a),
        .rd_operand_b(rd_operand_b), .rd_result(rd_result),
        .rd_valid(rd_valid), .rd_err(rd_err), .rd_pending(rd_pending),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          mask;   // 1: compare status only (valid, pending, count, ready)
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] res;
        logic        v, e, p, rdy;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_cnt;

    // Monitor: read ports are always presented; pop one expectation per cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t x;
            bit   ok;
            x = sbq.pop_front();
            total++;
            if (x.mask)
                ok = (rd_valid === x.v) && (rd_pending === x.p) &&
                     (load_count === x.cnt) && (load_ready === x.rdy);
            else
                ok = (rd_opcode === x.op) && (rd_operand_a === x.a) &&
                     (rd_operand_b === x.b) && (rd_result === x.res) &&
                     (rd_valid === x.v) && (rd_err === x.e) && (rd_pending === x.p) &&
                     (load_count === x.cnt) && (load_ready === x.rdy);
            if (!ok) begin
                bad++;
                $display("FAIL %s: got op=%0d a=%h b=%h res=%h v=%b e=%b p=%b cnt=%0d rdy=%b want op=%0d a=%h b=%h res=%h v=%b e=%b p=%b cnt=%0d rdy=%b",
                         x.name, rd_opcode, rd_operand_a, rd_operand_b, rd_result,
                         rd_valid, rd_err, rd_pending, load_count, load_ready,
                         x.op, x.a, x.b, x.res, x.v, x.e, x.p, x.cnt, x.rdy);
            end
        end
    end

    task automatic chk(input string nm, input logic [4:0] ptr, input bit mask,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input logic v, input logic e,
                       input logic p, input logic [15:0] cnt, input logic rdy);
        exp_t x;
        read_pointer = ptr;
        x.name = nm; x.mask = mask; x.op = op; x.a = a; x.b = b; x.res = res;
        x.v = v; x.e = e; x.p = p; x.cnt = cnt; x.rdy = rdy;
        sbq.push_back(x);
        for (int k = 0; k < 4 && sbq.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: monitor timeout, queue=%0d want 0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic load(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] ptr);
        opcode = op; operand_a = a; operand_b = b; write_pointer = ptr;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt++;
    endtask

    task automatic idle();
        load_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load_valid = 1'b0; clear = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_cnt = 16'd0;
        step();
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] ptr,
                          input logic [63:0] res, input logic e);
        load(op, a, b, ptr);
        idle();
        step();
        chk(nm, ptr, 1'b0, op, a, b, res, 1'b1, e, 1'b0, exp_cnt, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; load_valid = 1'b0;
        opcode = '0; operand_a = '0; operand_b = '0;
        write_pointer = '0; read_pointer = '0;
        exp_cnt = 16'd0;
        do_reset();

        for (int i = 0; i < 32; i++)
            chk($sformatf("reset_e%0d", i), 5'(i), 1'b0, 3'd0, 32'd0, 32'd0, 64'd0,
                1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

        // ADD -5 + 3 into entry 4: pending after E0, written after E0+1
        load(3'd3, 32'hFFFF_FFFB, 32'd3, 5'd4);
        idle();
        chk("add_pending", 5'd4, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
        step();
        chk("add_result", 5'd4, 1'b0, 3'd3, 32'hFFFF_FFFB, 32'd3, 64'hFFFF_FFFF_FFFF_FFFE,
            1'b1, 1'b0, 1'b0, 16'd1, 1'b1);

        run_op("mult", 3'd5, 32'h8000_0000, 32'd2, 5'd5, 64'hFFFF_FFFF_0000_0000, 1'b0);
`ifdef IR_DIV_EN
        run_op("div",      3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6,  64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("mod",      3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("div_zero", 3'd6, 32'd9,         32'd0, 5'd9,  64'd0, 1'b1);
        run_op("div_9_3",  3'd6, 32'd9,         32'd3, 5'd10, 64'd3, 1'b0);
`else
        run_op("div",      3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6,  64'd0, 1'b1);
        run_op("mod",      3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8,  64'd0, 1'b1);
        run_op("div_zero", 3'd6, 32'd9,         32'd0, 5'd9,  64'd0, 1'b1);
        run_op("div_9_3",  3'd6, 32'd9,         32'd3, 5'd10, 64'd0, 1'b1);
`endif
        run_op("zero",  3'd0, 32'd5,         32'd6,         5'd11, 64'd0, 1'b0);
        run_op("passa", 3'd1, 32'hFFFF_FFFE, 32'd6,         5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("passb", 3'd2, 32'd1,         32'h7FFF_FFFF, 5'd13, 64'h0000_0000_7FFF_FFFF, 1'b0);
        run_op("sub",   3'd4, 32'd3,         32'd10,        5'd14, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);

        // Back-to-back loads to the same entry: the later one wins
        load(3'd3, 32'd1, 32'd1, 5'd15);
        load(3'd4, 32'd10, 32'd1, 5'd15);
        idle();
        chk("b2b_first", 5'd15, 1'b0, 3'd3, 32'd1, 32'd1, 64'd2, 1'b1, 1'b0, 1'b1, 16'd12, 1'b1);
        step();
        chk("b2b_last", 5'd15, 1'b0, 3'd4, 32'd10, 32'd1, 64'd9, 1'b1, 1'b0, 1'b0, 16'd12, 1'b1);

        // Clear drops valid bits of existing entries
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_e4", 5'd4, 1'b1, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 16'd12, 1'b1);

        // Load into 7, then clear with load_valid held the next cycle
        do_reset();
        load(3'd3, 32'd1, 32'd2, 5'd7);
        clear = 1'b1;
        opcode = 3'd3; operand_a = 32'd4; operand_b = 32'd4; write_pointer = 5'd3;
        chk("clr_ready", 5'd7, 1'b1, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
        step();
        clear = 1'b0;
        idle();
        step();
        chk("clr_e7", 5'd7, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
        chk("clr_e3", 5'd3, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);

        // 65537 consecutive loads wrap the counter to 1
        do_reset();
        for (int i = 0; i < 65537; i++)
            load(3'd0, 32'd1, 32'd2, 5'd0);
        idle();
        step();
        chk("cnt_wrap", 5'd0, 1'b0, 3'd0, 32'd1, 32'd2, 64'd0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b1);

        // Reset asserted while a load sits in stage-1
        load(3'd3, 32'd1, 32'd1, 5'd20);
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("rst_midop", 5'd20, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
